hdmi_pll_supervisor: RTL and testbench
======================================

Name: hdmi_pll_supervisor

Overview:
- Sequences the HDMI PLL (48 MHz in; 252 MHz TMDS and 25.2 MHz pixel clocks out) from power-up through stable operation.
- Drives the PLL reset, qualifies its LOCK output, and holds the video-domain reset until lock has been stable for a programmable time.
- On a PLL that never locks or loses lock, it re-resets the PLL with bounded retries, then latches a fault.
- Runs entirely on the 48 MHz reference clock; downstream video domains re-synchronize video_rst_n locally.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 48000: cycles allowed in WAIT_LOCK (1 ms at 48 MHz) before retry.
- STABLE_CYCLES, 4800: consecutive synchronized-locked cycles required before release (100 µs).
- MAX_RETRIES, 7: failed lock attempts tolerated before FAULT (1..15).
- SYNC_STAGES, 2: synchronizer depth on pll_locked (≥2).

Ports:
- clk  in  1  48 MHz reference clock, same net as PLL input clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = bring up and keep PLL running, 0 = hold everything in reset
- pll_locked  in  1  PLL LOCK, asynchronous to clk
- pll_rst  out  1  to PLL RST, active high
- video_rst_n  out  1  active-low reset for pixel/TMDS logic
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- state  out  3  encoded FSM state for debug/LED
- retry_cnt  out  4  failed attempts in current bring-up
- lock_loss_cnt  out  8  lock losses seen in RUN, saturating at 255

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pll_rst=1, video_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0, timers=0.
- All outputs are registered. lk_s is pll_locked after SYNC_STAGES flops.
- State encodings: IDLE=0, PLL_RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- IDLE:
  - Outputs: pll_rst=1, video_rst_n=0.
  - enable=1 → PLL_RESET with timer cleared and retry_cnt=0.
- PLL_RESET:
  - pll_rst=1 for exactly RST_CYCLES cycles, then → WAIT_LOCK.
  - pll_rst is low from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Timer counts from 0.
  - lk_s=1 → STABLE.
  - Timer reaches LOCK_TIMEOUT-1 with lk_s=0: retry_cnt++.
    - If the new retry_cnt equals MAX_RETRIES → FAULT.
    - Otherwise → PLL_RESET.
  - If lk_s rises on the same cycle the timeout expires, lock wins.
- STABLE:
  - Counter counts consecutive lk_s=1 cycles.
  - lk_s=0 → back to WAIT_LOCK; the WAIT_LOCK timer restarts at 0 and retry_cnt is unchanged.
  - STABLE_CYCLES reached → RUN.
- RUN:
  - video_rst_n=1 and ready=1 from the first RUN cycle.
  - lk_s=0 → video_rst_n=0 on the next clock edge, lock_loss_cnt++ (saturating), retry_cnt=0, → PLL_RESET.
- FAULT:
  - pll_rst=1, video_rst_n=0, fault=1.
  - Leaves only via enable=0 → IDLE.
- enable=0 in any state → IDLE on the next edge; video_rst_n=0 and pll_rst=1 on that same edge.
  - This holds even mid-RST_CYCLES or mid-STABLE.
  - lock_loss_cnt is retained; retry_cnt clears on re-entry to PLL_RESET.
- Timer width: clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)+1). One shared timer clears on every state change.
- Invariant: video_rst_n=1 implies state=RUN and lk_s=1 on the previous cycle.

Decomposition:
- Package hdmi_clk_pkg:
  - state enum type and its encodings
  - default timing constants (RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) in 48 MHz cycles
- Sub-module sync_ff:
  - Parameterized N-stage synchronizer, reset to 0.
  - Reusable by video domains for video_rst_n.

Test Plan:
(All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2.)
- Clean bring-up: enable=1, pll_locked rises 10 cycles after pll_rst falls and stays high → pll_rst high exactly 4 cycles; video_rst_n rises 2+8 (+1 transition) cycles after lock; ready=1; retry_cnt=0.
- No lock: pll_locked held 0 → three PLL_RESET/WAIT_LOCK cycles, each pll_rst pulse 4 cycles and spaced 20 cycles apart; then fault=1, state=5, retry_cnt=3, video_rst_n stays 0.
- Glitchy lock: pll_locked high 5 cycles, low 1, then high → STABLE aborts to WAIT_LOCK; release only after 8 consecutive synced cycles; retry_cnt=0.
- Lock loss in RUN: drop pll_locked for 1 cycle → video_rst_n=0 within SYNC_STAGES+1 cycles; lock_loss_cnt=1; new 4-cycle pll_rst pulse; re-RUN after relock.
- Disable mid-STABLE, then FAULT recovery: enable=0 → IDLE next edge with pll_rst=1. From FAULT, enable toggle 0→1 → fault=0 and a fresh bring-up with retry_cnt=0.
- Async reset mid-RUN: rst_n low for a non-clock-aligned pulse → all outputs at reset values immediately and lock_loss_cnt=0; resume bring-up only after enable seen with rst_n=1.

Source files
------------

// File: rtl/hdmi_clk_pkg.sv
// Shared types and default timing for the HDMI clock subsystem.
// All timing constants are in 48 MHz reference-clock cycles.
package hdmi_clk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLL_RESET = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } pll_state_e;

   localparam int RST_CYCLES_DEF    = 16;     // PLL reset pulse width
   localparam int LOCK_TIMEOUT_DEF  = 48000;  // 1 ms
   localparam int STABLE_CYCLES_DEF = 4800;   // 100 us

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer with async active-low clear.
// Also usable by the video domains to re-time video_rst_n.
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// HDMI PLL bring-up supervisor: drives PLL reset, qualifies LOCK, retries,
// and releases the video-domain reset only after lock has been stable.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | enable low; PLL and video held in reset
//   PLL_RESET | pll_rst pulse of RST_CYCLES cycles
//   WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
//   STABLE    | counting consecutive locked cycles up to STABLE_CYCLES
//   RUN       | video released; any lock drop restarts the PLL
//   FAULT     | MAX_RETRIES failed attempts; exits only on enable low
module hdmi_pll_supervisor
   import hdmi_clk_pkg::*;
#(
   parameter int RST_CYCLES    = RST_CYCLES_DEF,
   parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int MAX_RETRIES   = 7,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       video_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam int TW = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES) + 1);

   logic          lk_s;
   pll_state_e    state_q, state_d;
   logic [TW-1:0] timer_q;
   logic          timer_inc;
   logic [3:0]    retry_d;
   logic [7:0]    loss_d;

   sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lk_s)
   );

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_cnt;
      loss_d    = lock_loss_cnt;
      timer_inc = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_PLL_RESET;
               retry_d = 4'd0;
            end
            ST_PLL_RESET: begin
               timer_inc = 1'b1;
               if (timer_q == TW'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               timer_inc = 1'b1;
               // lock takes priority over a simultaneous timeout
               if (lk_s) begin
                  state_d = ST_STABLE;
               end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                  retry_d = retry_cnt + 4'd1;
                  state_d = (retry_cnt + 4'd1 == 4'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RESET;
               end
            end
            ST_STABLE: begin
               timer_inc = 1'b1;
               if (!lk_s)                                    state_d = ST_WAIT_LOCK;
               else if (timer_q == TW'(STABLE_CYCLES - 1))   state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!lk_s) begin
                  state_d = ST_PLL_RESET;
                  retry_d = 4'd0;
                  if (lock_loss_cnt != 8'hFF) loss_d = lock_loss_cnt + 8'd1;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         retry_cnt     <= 4'd0;
         lock_loss_cnt <= 8'd0;
         pll_rst       <= 1'b1;
         video_rst_n   <= 1'b0;
         ready         <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state_q       <= state_d;
         retry_cnt     <= retry_d;
         lock_loss_cnt <= loss_d;
         if (state_d != state_q) timer_q <= '0;
         else if (timer_inc)     timer_q <= timer_q + TW'(1);
         pll_rst     <= (state_d == ST_IDLE) || (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
         video_rst_n <= (state_d == ST_RUN);
         ready       <= (state_d == ST_RUN);
         fault       <= (state_d == ST_FAULT);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Directed bench for hdmi_pll_supervisor with small timing parameters.
module tb_hdmi_pll_supervisor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       pll_locked;
   logic       pll_rst;
   logic       video_rst_n;
   logic       ready;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int checks   = 0;
   int failures = 0;

   hdmi_pll_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3),
      .SYNC_STAGES   (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .pll_locked    (pll_locked),
      .pll_rst       (pll_rst),
      .video_rst_n   (video_rst_n),
      .ready         (ready),
      .fault         (fault),
      .state         (state),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n      = 1'b0;
      enable     = 1'b0;
      pll_locked = 1'b0;
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_video", video_rst_n, 0);
      chk("rst_ready", ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_retry", retry_cnt, 0);
      chk("rst_loss", lock_loss_cnt, 0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_hold", state, 0);

      // clean bring-up
      enable = 1'b1;
      tick(1);
      chk("up_state_rst", state, 1);
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin n++; tick(1); end
      chk("up_rst_width", n, 4);
      chk("up_wait_state", state, 2);
      tick(10);
      pll_locked = 1'b1;
      tick(3);
      chk("up_stable", state, 3);
      tick(7);
      chk("up_stable_hold", state, 3);
      chk("up_video_low", video_rst_n, 0);
      tick(1);
      chk("up_run", state, 4);
      chk("up_video", video_rst_n, 1);
      chk("up_ready", ready, 1);
      chk("up_retry", retry_cnt, 0);
      chk("up_pll_rst", pll_rst, 0);

      // one-cycle lock loss in RUN
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(1);
      chk("loss_video_still", video_rst_n, 1);
      tick(1);
      chk("loss_video", video_rst_n, 0);
      chk("loss_state", state, 1);
      chk("loss_cnt", lock_loss_cnt, 1);
      chk("loss_retry", retry_cnt, 0);
      chk("loss_ready", ready, 0);
      n = 0;
      while (pll_rst === 1'b1 && n < 20) begin n++; tick(1); end
      chk("loss_rst_width", n, 4);
      tick(1);
      chk("loss_stable", state, 3);
      tick(8);
      chk("loss_rerun", state, 4);
      chk("loss_rerun_video", video_rst_n, 1);

      // disable from RUN, then glitchy lock
      enable     = 1'b0;
      pll_locked = 1'b0;
      tick(1);
      chk("dis_state", state, 0);
      chk("dis_pll_rst", pll_rst, 1);
      chk("dis_video", video_rst_n, 0);
      chk("dis_loss_kept", lock_loss_cnt, 1);
      enable = 1'b1;
      tick(1);
      chk("gl_rst", state, 1);
      tick(4);
      chk("gl_wait", state, 2);
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(1);
      chk("gl_stable1", state, 3);
      tick(1);
      chk("gl_abort", state, 2);
      tick(1);
      chk("gl_stable2", state, 3);
      tick(7);
      chk("gl_not_yet", video_rst_n, 0);
      tick(1);
      chk("gl_run", state, 4);
      chk("gl_video", video_rst_n, 1);
      chk("gl_retry", retry_cnt, 0);

      // disable mid-STABLE
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(1);
      chk("ms_rst", state, 1);
      tick(5);
      chk("ms_stable", state, 3);
      tick(3);
      enable = 1'b0;
      tick(1);
      chk("ms_idle", state, 0);
      chk("ms_pll_rst", pll_rst, 1);
      chk("ms_video", video_rst_n, 0);

      // no lock: three attempts then FAULT
      pll_locked = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("nl_retry_%0d", k), retry_cnt, k);
         n = 0;
         while (pll_rst === 1'b1 && n < 50) begin n++; tick(1); end
         chk($sformatf("nl_pulse_%0d", k), n, 4);
         n = 0;
         while (pll_rst === 1'b0 && n < 50) begin
            if (video_rst_n !== 1'b0) chk("nl_video_low", video_rst_n, 0);
            n++; tick(1);
         end
         chk($sformatf("nl_gap_%0d", k), n, 20);
      end
      chk("nl_state", state, 5);
      chk("nl_fault", fault, 1);
      chk("nl_retry", retry_cnt, 3);
      chk("nl_video", video_rst_n, 0);
      chk("nl_pll_rst", pll_rst, 1);
      tick(10);
      chk("nl_sticky", state, 5);

      // FAULT recovery
      enable     = 1'b0;
      pll_locked = 1'b1;
      tick(1);
      chk("fr_idle", state, 0);
      chk("fr_fault", fault, 0);
      tick(2);
      enable = 1'b1;
      tick(1);
      chk("fr_rst", state, 1);
      chk("fr_retry", retry_cnt, 0);
      n = 0;
      while (ready !== 1'b1 && n < 60) begin n++; tick(1); end
      chk("fr_run_latency", n, 13);
      chk("fr_run", state, 4);

      // async reset mid-RUN, not clock aligned
      #2 rst_n = 1'b0;
      #1;
      chk("ar_state", state, 0);
      chk("ar_pll_rst", pll_rst, 1);
      chk("ar_video", video_rst_n, 0);
      chk("ar_ready", ready, 0);
      chk("ar_loss", lock_loss_cnt, 0);
      @(posedge clk);
      #1;
      chk("ar_hold", state, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("ar_post_idle", state, 0);
      tick(1);
      chk("ar_resume", state, 1);
      chk("ar_resume_loss", lock_loss_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
